// File: rtl/ram_regfile_2r1w.sv
// ram_regfile_2r1w
//   Single-clock register-file RAM: one lane-masked write port, two
//   independent registered read ports with write-first forwarding.
//   After reset a clear sequencer zeroes every entry, then ready_o rises.
//
// Ports
//   clk_i      sole clock, rising edge
//   reset_i    synchronous active-low reset
//   ready_o    1 once the clear sweep has finished
//   wen_i      write strobe
//   wmask_i    per-lane write enable (LANES bits)
//   waddr_i    write address
//   wdata_i    write data
//   ren_a_i    port A read strobe
//   raddr_a_i  port A address
//   rdata_a_o  port A read data, 1-cycle latency, holds when idle
//   ren_b_i    port B read strobe
//   raddr_b_i  port B address
//   rdata_b_o  port B read data, 1-cycle latency, holds when idle
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | sweeping zeros into mem[ptr]; accesses ignored, outputs at 0
// RUN   | normal read/write operation; ready_o=1
module ram_regfile_2r1w #(
    parameter int DATA_W = 64,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       ready_o,
    input  logic                       wen_i,
    input  logic [DATA_W/LANE_W-1:0]   wmask_i,
    input  logic [ADDR_W-1:0]          waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       ren_a_i,
    input  logic [ADDR_W-1:0]          raddr_a_i,
    output logic [DATA_W-1:0]          rdata_a_o,
    input  logic                       ren_b_i,
    input  logic [ADDR_W-1:0]          raddr_b_i,
    output logic [DATA_W-1:0]          rdata_b_o
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   wr_word;

    // Word as it will look after this edge's write: new data in masked
    // lanes, old contents elsewhere. Also used as the forwarding value.
    always_comb begin
        wr_word = mem[waddr_i];
        for (int k = 0; k < LANES; k++) begin
            if (wmask_i[k]) begin
                wr_word[k*LANE_W +: LANE_W] = wdata_i[k*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST) begin
                    state_d = ST_RUN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                if (ren_a_i) begin
                    rdata_a_d = (wen_i && (waddr_i == raddr_a_i)) ? wr_word : mem[raddr_a_i];
                end
                if (ren_b_i) begin
                    rdata_b_d = (wen_i && (waddr_i == raddr_b_i)) ? wr_word : mem[raddr_b_i];
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_CLEAR;
            ptr_q     <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    // Storage has no reset of its own; the sweep zeroes it instead, and a
    // write presented on a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (state_q == ST_CLEAR) begin
                mem[ptr_q] <= '0;
            end else if (wen_i) begin
                mem[waddr_i] <= wr_word;
            end
        end
    end

    assign ready_o   = (state_q == ST_RUN);
    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: tb/tb_ram_regfile_2r1w.sv
module tb_ram_regfile_2r1w;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        ready_o;
    logic        wen_i = 1'b0;
    logic [3:0]  wmask_i = '0;
    logic [4:0]  waddr_i = '0;
    logic [63:0] wdata_i = '0;
    logic        ren_a_i = 1'b0;
    logic [4:0]  raddr_a_i = '0;
    logic [63:0] rdata_a_o;
    logic        ren_b_i = 1'b0;
    logic [4:0]  raddr_b_i = '0;
    logic [63:0] rdata_b_o;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [63:0] m_mem [32];
    int          m_cnt = 0;
    logic        m_rdy = 1'b0;
    logic [63:0] m_a = '0;
    logic [63:0] m_b = '0;

    always #5 clk = ~clk;

    ram_regfile_2r1w dut (
        .clk_i(clk), .reset_i(reset_i), .ready_o(ready_o),
        .wen_i(wen_i), .wmask_i(wmask_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .ren_a_i(ren_a_i), .raddr_a_i(raddr_a_i), .rdata_a_o(rdata_a_o),
        .ren_b_i(ren_b_i), .raddr_b_i(raddr_b_i), .rdata_b_o(rdata_b_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the model, sample #1 after the edge.
    task automatic cyc(input logic rst, input logic we, input logic [3:0] m,
                       input logic [4:0] wa, input logic [63:0] wd,
                       input logic ea, input logic [4:0] aa,
                       input logic eb, input logic [4:0] ab);
        logic [63:0] merged;
        reset_i = rst; wen_i = we; wmask_i = m; waddr_i = wa; wdata_i = wd;
        ren_a_i = ea; raddr_a_i = aa; ren_b_i = eb; raddr_b_i = ab;
        if (!rst) begin
            m_cnt = 0; m_rdy = 1'b0; m_a = '0; m_b = '0;
        end else if (!m_rdy) begin
            m_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_rdy = 1'b1;
        end else begin
            merged = m_mem[wa];
            for (int k = 0; k < 4; k++)
                if (m[k]) merged[k*16 +: 16] = wd[k*16 +: 16];
            if (ea) m_a = (we && wa == aa) ? merged : m_mem[aa];
            if (eb) m_b = (we && wa == ab) ? merged : m_mem[ab];
            if (we) m_mem[wa] = merged;
        end
        @(posedge clk);
        #1;
        chk("ready", {63'd0, ready_o}, {63'd0, m_rdy});
        chk("rdata_a", rdata_a_o, m_a);
        chk("rdata_b", rdata_b_o, m_b);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] m, input logic [63:0] d);
        cyc(1'b1, 1'b1, m, a, d, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // Clear sweep with every strobe randomly driven; all must be ignored.
    task automatic noisy_sweep();
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 1'b1, 4'($urandom), 5'($urandom), {$urandom, $urandom},
                1'b1, 5'($urandom), 1'b1, 5'($urandom));
    endtask

    initial begin
        // reset held 3 edges, then a quiet sweep
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 4'h0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 31; i++) idle();
        chk("ready_before_32", {63'd0, ready_o}, 64'd0);
        idle();
        chk("ready_after_32", {63'd0, ready_o}, 64'd1);
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
        chk("clear_a31", rdata_a_o, 64'd0);

        // lane-masked write
        wr(5'd5, 4'b1111, 64'h1111_2222_3333_4444);
        wr(5'd5, 4'b0101, 64'hAAAA_BBBB_CCCC_DDDD);
        wr(5'd5, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b1, 5'd5, 1'b0, 5'd0);
        chk("masked_write", rdata_a_o, 64'h1111_BBBB_3333_DDDD);

        // write-first forwarding on A, unaffected B
        wr(5'd7, 4'hF, 64'h0123_4567_89AB_CDEF);
        wr(5'd6, 4'hF, 64'h6666_5555_4444_3333);
        cyc(1'b1, 1'b1, 4'b1000, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd7, 1'b1, 5'd6);
        chk("fwd_a", rdata_a_o, 64'hFFFF_4567_89AB_CDEF);
        chk("fwd_b", rdata_b_o, 64'h6666_5555_4444_3333);

        // hold and independence
        for (int i = 0; i < 5; i++) wr(5'(i), 4'hF, 64'h11 * (i + 1));
        wr(5'd3, 4'hF, 64'h33);
        cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b1, 5'(i));
            chk("hold_a", rdata_a_o, 64'h33);
        end

        // reset mid-run with a write on the reset edge
        wr(5'd9, 4'hF, 64'hDEAD);
        cyc(1'b0, 1'b1, 4'hF, 5'd10, 64'hBEEF, 1'b1, 5'd9, 1'b1, 5'd10);
        chk("rst_out_a", rdata_a_o, 64'd0);
        noisy_sweep();
        chk("ready_after_rst", {63'd0, ready_o}, 64'd1);
        cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b1, 5'd10);
        chk("rst_a9", rdata_a_o, 64'd0);
        chk("rst_b10", rdata_b_o, 64'd0);
        for (int i = 0; i < 32; i++)
            cyc(1'b1, 1'b0, 4'h0, 5'd0, 64'd0, 1'b1, 5'(i), 1'b0, 5'd0);

        // random traffic on a narrow address range to provoke collisions
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(199) != 0), 1'($urandom), 4'($urandom),
                5'($urandom_range(3)), {$urandom, $urandom},
                1'($urandom), 5'($urandom_range(3)),
                1'($urandom), 5'($urandom_range(3)));
        end
        // random traffic over the full range
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'($urandom), 4'($urandom), 5'($urandom), {$urandom, $urandom},
                1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_regfile_2r1w.md
Name: ram_regfile_2r1w

Overview:
- Parametrised single-clock register-file RAM with one write port and two independent read ports (A, B).
- Successor to the fixed 64x32 column RAM: configurable width and depth, per-lane write masking, read enables and write-first forwarding.
- Built-in post-reset clear sequencer zeroes every entry before the core may use it.
- Sits under the CPU integer register file and other small scratch stores.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of LANE_W.
- LANE_W, 16, write-mask lane width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- LANES (derived, not overridable), DATA_W/LANE_W, number of write-mask bits.

Ports:
- clk_i  in  1  sole clock, rising edge.
- reset_i  in  1  synchronous, active-low reset.
- ready_o  out  1  1 = clear sweep finished; array accepts accesses.
- wen_i  in  1  write strobe.
- wmask_i  in  LANES  per-lane write enable; bit k covers wdata_i[k*LANE_W +: LANE_W].
- waddr_i  in  ADDR_W  write address.
- wdata_i  in  DATA_W  write data.
- ren_a_i  in  1  port A read strobe.
- raddr_a_i  in  ADDR_W  port A address.
- rdata_a_o  out  DATA_W  port A registered read data.
- ren_b_i  in  1  port B read strobe.
- raddr_b_i  in  ADDR_W  port B address.
- rdata_b_o  out  DATA_W  port B registered read data.

Behaviour:
- Reset: any edge with reset_i=0 puts the block in CLEAR with the clear pointer at 0.
  - Same edge: ready_o=0, rdata_a_o=0, rdata_b_o=0.
  - Array contents are not touched on that edge.
- FSM has two states, CLEAR and RUN.
- CLEAR, each edge with reset_i=1:
  - Writes all-zero to entry ptr; ptr increments.
  - On the edge that writes entry DEPTH-1: go to RUN and set ready_o=1.
  - ready_o is therefore high after exactly DEPTH edges with reset_i=1 (32 at default).
  - wen_i, ren_a_i and ren_b_i are ignored; both rdata outputs hold 0.
- RUN, write:
  - Edge with wen_i=1: mem[waddr_i] lane k takes wdata_i lane k for each wmask_i[k]=1; other lanes keep their value.
  - wen_i=1 with wmask_i=0 is a no-op.
- RUN, read:
  - Edge with ren_x_i=1: rdata_x_o takes mem[raddr_x_i]. Latency is 1 cycle; data is valid the cycle after the strobe.
  - ren_x_i=0: rdata_x_o holds its previous value indefinitely.
  - Ports A and B are fully independent and may use the same address.
- Read-during-write, same edge, same address: write-first. rdata_x_o returns the merged word:
  - wdata_i in lanes whose mask bit is 1;
  - old contents in all other lanes.
  - Applies to each port independently.
- Different addresses on the same edge: no interaction.
- Reset mid-operation (any state, any cycle):
  - Immediately returns to CLEAR, ptr=0, ready_o=0, outputs 0.
  - A write presented on that edge is discarded.
  - The sweep then restarts from entry 0.
- Addresses are ADDR_W bits, so every address is in range and there is no wrap-around hazard.
- The clear pointer stops at DEPTH-1 and never wraps while in RUN.
- Implementation freedom:
  - The storage array may be inferred as distributed RAM, but the 2-read/1-write timing above is mandatory.
  - The zeroing write and forwarding mux must not add latency.

Test Plan:
- Clear timing: hold reset_i=0 for 3 edges, release. ready_o must be 0 for edges 1..31 and 1 after edge 32. Then read all 32 entries on A and B; every word must be 0x0.
- Lane-masked write: write 0x1111_2222_3333_4444 to addr 5 with mask 4'b1111, then 0xAAAA_BBBB_CCCC_DDDD with mask 4'b0101. Read addr 5 on A: 0x1111_BBBB_3333_DDDD.
- Write-first forwarding: addr 7 holds 0x0123_4567_89AB_CDEF. On one edge write 0xFFFF_FFFF_FFFF_FFFF mask 4'b1000 to addr 7, with A reading 7 and B reading 6. Next cycle A must be 0xFFFF_4567_89AB_CDEF and B must be mem[6].
- Hold and independence: A reads addr 3 (0x33), then ren_a_i=0 for 5 cycles while B streams addrs 0..4. rdata_a_o must stay 0x33; B must return each entry one cycle after its strobe.
- Ignored during clear: assert wen_i, ren_a_i and ren_b_i throughout the sweep. No entry may become nonzero, and both outputs must stay 0 until ready_o=1.
- Reset mid-run: after writing 0xDEAD to addr 9, pull reset_i low for 1 edge while also writing addr 10. After re-release, ready_o must return after 32 edges, and addrs 9 and 10 must both read 0.
